// File: rtl/comparator_2bit_triple.sv
// Registered 2-bit unsigned comparator with three independent implementations
// (gate primitives, behavioural expressions, truth table) and a disagreement flag.
module comparator_2bit_triple (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       out_valid,
  output logic       eq_gates,
  output logic       geq_gates,
  output logic       lt_gates,
  output logic       eq_expr,
  output logic       geq_expr,
  output logic       lt_expr,
  output logic       eq_tt,
  output logic       geq_tt,
  output logic       lt_tt,
  output logic       mismatch
);

  // Gate-level path: bitwise equality terms feed both eq and the lt decision.
  logic d1, d0, x1, x0;
  logic na1, na0;
  logic lt_hi, lt_lo;
  logic eq_g, lt_g, geq_g;

  xor g_d1   (d1, a[1], b[1]);
  xor g_d0   (d0, a[0], b[0]);
  not g_x1   (x1, d1);
  not g_x0   (x0, d0);
  and g_eq   (eq_g, x1, x0);
  not g_na1  (na1, a[1]);
  not g_na0  (na0, a[0]);
  and g_lthi (lt_hi, na1, b[1]);
  and g_ltlo (lt_lo, x1, na0, b[0]);
  or  g_lt   (lt_g, lt_hi, lt_lo);
  not g_geq  (geq_g, lt_g);

  logic [2:0] res_gates;
  assign res_gates = {eq_g, geq_g, lt_g};

  logic [2:0] res_expr;

  always_comb begin
    res_expr    = 3'b000;
    res_expr[2] = (a == b);
    res_expr[1] = (a >= b);
    res_expr[0] = (a < b);
  end

  // Truth table, packed as {eq, geq, lt}, indexed by {a, b}.
  logic [2:0] res_tt;

  always_comb begin
    res_tt = 3'b000;
    case ({a, b})
      4'b00_00: res_tt = 3'b110;
      4'b00_01: res_tt = 3'b001;
      4'b00_10: res_tt = 3'b001;
      4'b00_11: res_tt = 3'b001;
      4'b01_00: res_tt = 3'b010;
      4'b01_01: res_tt = 3'b110;
      4'b01_10: res_tt = 3'b001;
      4'b01_11: res_tt = 3'b001;
      4'b10_00: res_tt = 3'b010;
      4'b10_01: res_tt = 3'b010;
      4'b10_10: res_tt = 3'b110;
      4'b10_11: res_tt = 3'b001;
      4'b11_00: res_tt = 3'b010;
      4'b11_01: res_tt = 3'b010;
      4'b11_10: res_tt = 3'b010;
      4'b11_11: res_tt = 3'b110;
      default:  res_tt = 3'b000;
    endcase
  end

  logic mismatch_next;
  assign mismatch_next = (res_gates != res_expr) | (res_gates != res_tt) | (res_expr != res_tt);

  // Results and flag hold while idle; only out_valid tracks in_valid every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      eq_gates  <= 1'b0;
      geq_gates <= 1'b0;
      lt_gates  <= 1'b0;
      eq_expr   <= 1'b0;
      geq_expr  <= 1'b0;
      lt_expr   <= 1'b0;
      eq_tt     <= 1'b0;
      geq_tt    <= 1'b0;
      lt_tt     <= 1'b0;
      mismatch  <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      {eq_gates, geq_gates, lt_gates} <= res_gates;
      {eq_expr, geq_expr, lt_expr}    <= res_expr;
      {eq_tt, geq_tt, lt_tt}          <= res_tt;
      mismatch  <= mismatch_next;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_comparator_2bit_triple.sv
// Scoreboard bench for comparator_2bit_triple: each driven cycle pushes the
// expected registered state, which is popped and compared one cycle later.
module tb_comparator_2bit_triple;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] a;
  logic [1:0] b;
  logic       out_valid;
  logic       eq_gates, geq_gates, lt_gates;
  logic       eq_expr, geq_expr, lt_expr;
  logic       eq_tt, geq_tt, lt_tt;
  logic       mismatch;

  comparator_2bit_triple dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .eq_gates  (eq_gates),
    .geq_gates (geq_gates),
    .lt_gates  (lt_gates),
    .eq_expr   (eq_expr),
    .geq_expr  (geq_expr),
    .lt_expr   (lt_expr),
    .eq_tt     (eq_tt),
    .geq_tt    (geq_tt),
    .lt_tt     (lt_tt),
    .mismatch  (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [2:0] res;
    logic       mm;
    int         idx;
  } exp_t;

  exp_t sb[$];
  int check_count = 0;
  int error_count = 0;
  int cycle_idx   = 0;

  // Reference state, kept apart from the DUT: results as {eq, geq, lt}.
  logic [2:0] model_res = 3'b000;

  task automatic checkOutput(input string tag, input int idx, input logic [2:0] got, input logic [2:0] want);
    check_count++;
    if (got !== want) begin
      error_count++;
      $display("[TB] FAIL %s at step %0d: got %b expected %b", tag, idx, got, want);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge and queue what the
  // registers must hold once the next rising edge has passed.
  task automatic applyStimulus(input logic r, input logic v, input logic [1:0] x, input logic [1:0] y);
    exp_t e;
    int diff;
    @(negedge clk);
    #1;
    rst      = r;
    in_valid = v;
    a        = x;
    b        = y;
    diff = int'(x) - int'(y);
    if (r) begin
      model_res = 3'b000;
    end else if (v) begin
      model_res[2] = (diff == 0);
      model_res[0] = (diff < 0);
      model_res[1] = !(diff < 0);
    end
    e.valid = v && !r;
    e.res   = model_res;
    e.mm    = 1'b0;
    e.idx   = cycle_idx;
    cycle_idx++;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("out_valid", e.idx, {2'b00, out_valid}, {2'b00, e.valid});
      checkOutput("gates",     e.idx, {eq_gates, geq_gates, lt_gates}, e.res);
      checkOutput("expr",      e.idx, {eq_expr, geq_expr, lt_expr}, e.res);
      checkOutput("tt",        e.idx, {eq_tt, geq_tt, lt_tt}, e.res);
      checkOutput("mismatch",  e.idx, {2'b00, mismatch}, {2'b00, e.mm});
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 2'd0;
    b        = 2'd0;

    // Reset held two cycles with a valid equal pair presented, then released.
    applyStimulus(1'b1, 1'b1, 2'd3, 2'd3);
    applyStimulus(1'b1, 1'b1, 2'd3, 2'd3);
    applyStimulus(1'b0, 1'b1, 2'd3, 2'd3);

    $display("[TB] exhaustive sweep");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 2'(i / 4), 2'(i % 4));
    end

    $display("[TB] sweep with reset in the middle");
    for (int i = 0; i < 16; i++) begin
      if (i == 8) applyStimulus(1'b1, 1'b1, 2'd3, 2'd0);
      applyStimulus(1'b0, 1'b1, 2'(i / 4), 2'(i % 4));
    end

    $display("[TB] spot checks");
    applyStimulus(1'b0, 1'b1, 2'd2, 2'd3);
    applyStimulus(1'b0, 1'b1, 2'd3, 2'd2);
    applyStimulus(1'b0, 1'b1, 2'd1, 2'd1);

    $display("[TB] hold");
    applyStimulus(1'b0, 1'b1, 2'd0, 2'd3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'd3, 2'd0);

    $display("[TB] alternation");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, (i % 2 == 0) ? 2'd0 : 2'd3, 2'd0);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    applyStimulus(1'b0, 1'b0, 2'd0, 2'd0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checkOutput("sb_drain", cycle_idx, {2'b00, sb.size() != 0}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/comparator_2bit_triple.md
# comparator_2bit_triple

Registered 2-bit magnitude comparator that computes A==B, A>=B and A<B with three independent internal implementations: gate-level, behavioural expressions, and a 16-entry truth table. All three result sets are exposed, with a disagreement flag. The block serves as a self-checking comparison primitive: downstream logic consumes any one result set, and verification or diagnostic logic watches the flag.

## Interface
Parameters:
- None. Operand width is fixed at 2 bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  qualifies a and b this cycle.
- a  input  2  unsigned operand A.
- b  input  2  unsigned operand B.
- out_valid  output  1  registered results correspond to a valid input.
- eq_gates, geq_gates, lt_gates  output  1 each  results from the gate-level implementation.
- eq_expr, geq_expr, lt_expr  output  1 each  results from the expression implementation.
- eq_tt, geq_tt, lt_tt  output  1 each  results from the truth-table implementation.
- mismatch  output  1  the three result sets disagree on the registered sample.

## Operation
- All operands are unsigned, with values 0..3.
- Gate-level implementation, built only from AND, OR, NOT and XOR primitives:
  - x1 = ~(a[1]^b[1]) and x0 = ~(a[0]^b[0]).
  - eq = x1 & x0.
  - lt = (~a[1] & b[1]) | (x1 & ~a[0] & b[0]).
  - geq = ~lt.
- Expression implementation: eq = (a==b), geq = (a>=b), lt = (a<b).
- Truth-table implementation: a full case on {a,b} with all 16 entries listed explicitly. The default branch drives all three results to 0. The default branch is unreachable for 2-bit inputs.
- Invariants for each set, for every valid input:
  - geq = ~lt.
  - eq implies geq.
  - Exactly one of {eq, a>b, lt} holds.
- mismatch_next = 1 if any of the three triples differs from the other two. With correct RTL it is always 0.
- Register update when in_valid=1:
  - All nine result bits load their combinational values.
  - mismatch loads mismatch_next.
  - out_valid loads 1.
- Register update when in_valid=0:
  - Result bits and mismatch hold their previous values.
  - out_valid loads 0.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N, and are valid during cycle N+1.
- Throughput is one comparison per cycle. There is no backpressure.
- Reset, when rst=1 at an edge:
  - out_valid=0, all nine result bits=0, mismatch=0.
  - Reset overrides in_valid.
  - The all-zero reset state deliberately breaks the geq=~lt invariant. Consumers must qualify results with out_valid.
- Reset asserted mid-stream: the sample presented in the reset cycle is discarded. The first post-reset result appears one cycle after the first in_valid=1 with rst=0.
- All outputs are driven directly from flops, with no combinational path from input to output.

## Test plan
- Exhaustive sweep: apply all 16 (a,b) pairs in order (0,0),(0,1)…(3,3), with in_valid=1 and one pair per cycle. Each sample gives the following results on all three triples, one cycle later:
  - a==b: eq=1, geq=1, lt=0.
  - a>b: eq=0, geq=1, lt=0.
  - a<b: eq=0, geq=0, lt=1.
  - mismatch=0 and out_valid=1 throughout.
- Spot checks:
  - a=2, b=3 gives lt=1, geq=0, eq=0.
  - a=3, b=2 gives geq=1, lt=0, eq=0.
  - a=1, b=1 gives eq=1, geq=1, lt=0.
- Hold: drive a=0, b=3 with in_valid=1, then in_valid=0 with a=3, b=0 for 3 cycles.
  - out_valid=0 during the hold.
  - Results stay at lt=1, geq=0, eq=0.
- Reset: hold rst=1 for 2 cycles while in_valid=1, a=3, b=3.
  - All outputs are 0 during reset.
  - After release, eq=geq=1 and lt=0 appear exactly 1 cycle later.
- Reset mid-stream: assert rst for 1 cycle in the middle of the sweep.
  - Outputs are 0 in the following cycle.
  - The sweep resumes correctly with no stale result emitted.
- Back-to-back alternation: toggle (0,0) and (3,0) every cycle for 8 cycles.
  - eq alternates 1,0,1,0…, geq stays 1, lt stays 0.
  - mismatch is never asserted.
